// File: rtl/banked_ram_ctrl.sv
// banked_ram_ctrl: NUM_BANKS simple-dual-port RAM banks sharing one write
// address and one read address. Writes go to the banks selected by a mask,
// reads return every bank at once, and a built-in sequencer zero-fills all
// banks one address per cycle.
module banked_ram_ctrl #(
  parameter int NUM_BANKS  = 8,
  parameter int BANK_DEPTH = 256,
  parameter int DATA_WIDTH = 16,
  localparam int AW = $clog2(BANK_DEPTH)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_wr_en,
  input  logic [NUM_BANKS-1:0]            i_wr_bank_mask,
  input  logic [AW-1:0]                   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  output logic                            o_wr_ready,
  input  logic                            i_rd_en,
  input  logic [AW-1:0]                   i_rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] o_rd_data,
  output logic                            o_rd_valid,
  input  logic                            i_clear_start,
  output logic                            o_busy,
  output logic                            o_clear_done
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LP_LAST = AW'(BANK_DEPTH - 1);
  localparam logic [AW-1:0] LP_ONE  = AW'(1);

  state_t                r_state;
  logic [AW-1:0]         r_cnt;
  logic                  r_clear_done;
  logic                  r_rd_valid;

  logic                  w_idle;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [NUM_BANKS-1:0]  w_mem_we;
  logic [AW-1:0]         w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;

  // Select between the clear sequencer and the user write port for the RAM write side.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_rd_acc   = w_idle & i_rd_en;
    w_wr_acc   = w_idle & i_wr_en & ~i_rst;
    w_mem_we   = {NUM_BANKS{1'b0}};
    w_mem_addr = i_wr_addr;
    w_mem_data = i_wr_data;
    if ((r_state == S_CLEAR) && !i_rst) begin
      // A reset edge mid-clear must not write one more zero.
      w_mem_we   = {NUM_BANKS{1'b1}};
      w_mem_addr = r_cnt;
      w_mem_data = {DATA_WIDTH{1'b0}};
    end else if (w_wr_acc) begin
      w_mem_we   = i_wr_bank_mask;
      w_mem_addr = i_wr_addr;
      w_mem_data = i_wr_data;
    end else begin
      w_mem_we   = {NUM_BANKS{1'b0}};
    end
  end

  // Clear sequencer: one zero-write per cycle, done pulse in the first IDLE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= {AW{1'b0}};
      r_clear_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clear_done <= 1'b0;
          if (i_clear_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= {AW{1'b0}};
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= r_cnt;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_state      <= S_IDLE;
            r_cnt        <= {AW{1'b0}};
            r_clear_done <= 1'b1;
          end else begin
            r_state      <= S_CLEAR;
            r_cnt        <= r_cnt + LP_ONE;
            r_clear_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= {AW{1'b0}};
          r_clear_done <= 1'b0;
        end
      endcase
    end
  end

  // Read-valid flag: high only in the cycle after an accepted read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_lane;

    // Bank storage write; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
      if (w_mem_we[g]) begin
        r_mem[w_mem_addr] <= w_mem_data;
      end
    end

    // Registered read lane; old data is returned on a same-address write (read-first).
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_lane <= {DATA_WIDTH{1'b0}};
      end else if (w_rd_acc) begin
        r_lane <= r_mem[i_rd_addr];
      end else begin
        r_lane <= r_lane;
      end
    end

    assign o_rd_data[g*DATA_WIDTH +: DATA_WIDTH] = r_lane;
  end

  assign o_busy       = (r_state == S_CLEAR);
  assign o_wr_ready   = ~o_busy;
  assign o_rd_valid   = r_rd_valid;
  assign o_clear_done = r_clear_done;

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Directed bench for banked_ram_ctrl: default 8x256x16 instance plus a small
// 1x2x8 and a large 16x1024x32 instance for lane mapping and clear length.
module tb_banked_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst;

  // default instance: 8 banks, 256 deep, 16 bit
  logic         wr_en, rd_en, clear_start;
  logic [7:0]   wr_mask, wr_addr, rd_addr;
  logic [15:0]  wr_data;
  logic         wr_ready, rd_valid, busy, clear_done;
  logic [127:0] rd_data;

  // small instance: 1 bank, 2 deep, 8 bit
  logic         s_wr_en, s_rd_en, s_clear_start;
  logic [0:0]   s_wr_mask, s_wr_addr, s_rd_addr;
  logic [7:0]   s_wr_data;
  logic         s_wr_ready, s_rd_valid, s_busy, s_clear_done;
  logic [7:0]   s_rd_data;

  // large instance: 16 banks, 1024 deep, 32 bit
  logic         b_wr_en, b_rd_en, b_clear_start;
  logic [15:0]  b_wr_mask;
  logic [9:0]   b_wr_addr, b_rd_addr;
  logic [31:0]  b_wr_data;
  logic         b_wr_ready, b_rd_valid, b_busy, b_clear_done;
  logic [511:0] b_rd_data;

  banked_ram_ctrl #(.NUM_BANKS(8), .BANK_DEPTH(256), .DATA_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_bank_mask(wr_mask),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .i_clear_start(clear_start), .o_busy(busy),
    .o_clear_done(clear_done)
  );

  banked_ram_ctrl #(.NUM_BANKS(1), .BANK_DEPTH(2), .DATA_WIDTH(8)) u_small (
    .i_clk(clk), .i_rst(rst), .i_wr_en(s_wr_en), .i_wr_bank_mask(s_wr_mask),
    .i_wr_addr(s_wr_addr), .i_wr_data(s_wr_data), .o_wr_ready(s_wr_ready),
    .i_rd_en(s_rd_en), .i_rd_addr(s_rd_addr), .o_rd_data(s_rd_data),
    .o_rd_valid(s_rd_valid), .i_clear_start(s_clear_start), .o_busy(s_busy),
    .o_clear_done(s_clear_done)
  );

  banked_ram_ctrl #(.NUM_BANKS(16), .BANK_DEPTH(1024), .DATA_WIDTH(32)) u_big (
    .i_clk(clk), .i_rst(rst), .i_wr_en(b_wr_en), .i_wr_bank_mask(b_wr_mask),
    .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .o_wr_ready(b_wr_ready),
    .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .o_rd_valid(b_rd_valid), .i_clear_start(b_clear_start), .o_busy(b_busy),
    .o_clear_done(b_clear_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] m, input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_mask = m; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic s_wr(input logic [0:0] a, input logic [7:0] d);
    s_wr_en = 1'b1; s_wr_mask = 1'b1; s_wr_addr = a; s_wr_data = d;
    step();
    s_wr_en = 1'b0;
  endtask

  task automatic s_rd(input logic [0:0] a);
    s_rd_en = 1'b1; s_rd_addr = a;
    step();
    s_rd_en = 1'b0;
  endtask

  task automatic b_wr(input logic [15:0] m, input logic [9:0] a, input logic [31:0] d);
    b_wr_en = 1'b1; b_wr_mask = m; b_wr_addr = a; b_wr_data = d;
    step();
    b_wr_en = 1'b0;
  endtask

  task automatic b_rd(input logic [9:0] a);
    b_rd_en = 1'b1; b_rd_addr = a;
    step();
    b_rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] exp_big;
    int nb;
    int bad_v;
    int bad_r;

    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
    wr_mask = 8'h00; wr_addr = 8'h00; rd_addr = 8'h00; wr_data = 16'h0000;
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_clear_start = 1'b0;
    s_wr_mask = 1'b0; s_wr_addr = 1'b0; s_rd_addr = 1'b0; s_wr_data = 8'h00;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_clear_start = 1'b0;
    b_wr_mask = 16'h0000; b_wr_addr = 10'h000; b_rd_addr = 10'h000; b_wr_data = 32'h0;
    step();
    step();

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_clear_done", clear_done, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 128'h0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    rst = 1'b0;
    step();

    // basic read with partial mask
    wr(8'hFF, 8'd3, 16'h1111);
    wr(8'b0000_0101, 8'd3, 16'hA5A5);
    rd(8'd3);
    chk("basic_valid", rd_valid, 1'b1);
    chk("basic_data", rd_data, 128'h1111_1111_1111_1111_1111_A5A5_1111_A5A5);
    step();
    chk("basic_valid_drop", rd_valid, 1'b0);
    chk("basic_data_hold", rd_data, 128'h1111_1111_1111_1111_1111_A5A5_1111_A5A5);

    // mask 0 write is a no-op
    wr(8'h00, 8'd3, 16'hDEAD);
    rd(8'd3);
    chk("mask0_noop", rd_data, 128'h1111_1111_1111_1111_1111_A5A5_1111_A5A5);

    // lane mapping: distinct value per bank
    for (int i = 0; i < 8; i++) begin
      wr(8'(1 << i), 8'd4, 16'(16'h1000 + i));
    end
    rd(8'd4);
    chk("lane_map", rd_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

    // read/write collision is read-first
    wr(8'hFF, 8'd7, 16'h0001);
    wr_en = 1'b1; wr_mask = 8'hFF; wr_addr = 8'd7; wr_data = 16'h00FF;
    rd_en = 1'b1; rd_addr = 8'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("collide_old", rd_data, {8{16'h0001}});
    rd(8'd7);
    chk("collide_new", rd_data, {8{16'h00FF}});

    // fill, then clear with a read issued alongside clear_start
    for (int a = 0; a < 256; a++) begin
      wr(8'hFF, 8'(a), {8'hC3, 8'(a)});
    end
    clear_start = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
    step();
    clear_start = 1'b0;
    chk("clr_enter_busy", busy, 1'b1);
    chk("clr_enter_valid", rd_valid, 1'b1);
    chk("clr_enter_data", rd_data, {8{16'hC305}});

    // traffic during clear is dropped; clear_start while busy is ignored
    wr_en = 1'b1; wr_mask = 8'hFF; wr_addr = 8'd10; wr_data = 16'h1234; rd_addr = 8'd10;
    nb = 1; bad_v = 0; bad_r = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) clear_start = 1'b1;
      if (i == 101) clear_start = 1'b0;
      step();
      if (!busy) break;
      nb++;
      if (rd_valid !== 1'b0) bad_v++;
      if (wr_ready !== 1'b0) bad_r++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("clr_busy_cycles", 32'(nb), 32'd256);
    chk("clr_rd_valid_low", 32'(bad_v), 32'd0);
    chk("clr_wr_ready_low", 32'(bad_r), 32'd0);
    chk("clr_done_pulse", clear_done, 1'b1);
    chk("clr_idle_valid", rd_valid, 1'b0);
    chk("clr_idle_ready", wr_ready, 1'b1);
    step();
    chk("clr_done_single", clear_done, 1'b0);
    rd(8'd0);
    chk("clr_addr0", rd_data, 128'h0);
    rd(8'd128);
    chk("clr_addr128", rd_data, 128'h0);
    rd(8'd255);
    chk("clr_addr255", rd_data, 128'h0);
    rd(8'd10);
    chk("clr_addr10", rd_data, 128'h0);

    // reset in the middle of a clear
    wr(8'hFF, 8'd200, 16'hBEEF);
    wr(8'hFF, 8'd0, 16'h7777);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 49; i++) step();
    chk("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", clear_done, 1'b0);
    chk("midrst_valid", rd_valid, 1'b0);
    chk("midrst_data", rd_data, 128'h0);
    chk("midrst_ready", wr_ready, 1'b1);
    rst = 1'b0;
    step();
    chk("midrst_no_done", clear_done, 1'b0);
    rd(8'd200);
    chk("midrst_addr200", rd_data, {8{16'hBEEF}});
    rd(8'd0);
    chk("midrst_addr0", rd_data, 128'h0);

    // small instance: 1 bank, depth 2
    s_wr(1'b1, 8'hA5);
    s_wr(1'b0, 8'h3C);
    s_rd(1'b1);
    chk("small_valid", s_rd_valid, 1'b1);
    chk("small_data1", s_rd_data, 8'hA5);
    s_rd(1'b0);
    chk("small_data0", s_rd_data, 8'h3C);
    s_clear_start = 1'b1;
    step();
    s_clear_start = 1'b0;
    nb = 0;
    while (s_busy && nb < 100) begin
      nb++;
      step();
    end
    chk("small_clr_cycles", 32'(nb), 32'd2);
    chk("small_clr_done", s_clear_done, 1'b1);
    s_rd(1'b1);
    chk("small_clr_data1", s_rd_data, 8'h00);
    s_rd(1'b0);
    chk("small_clr_data0", s_rd_data, 8'h00);

    // large instance: 16 banks, depth 1024, 32 bit
    exp_big = '0;
    for (int i = 0; i < 16; i++) begin
      b_wr(16'(1 << i), 10'd3, 32'(32'hB000_0000 + i));
      exp_big[i*32 +: 32] = 32'(32'hB000_0000 + i);
    end
    b_rd(10'd3);
    chk("big_valid", b_rd_valid, 1'b1);
    chk("big_lane_map", b_rd_data, exp_big);
    b_wr(16'h0005, 10'd3, 32'hA5A5_A5A5);
    exp_big[0*32 +: 32] = 32'hA5A5_A5A5;
    exp_big[2*32 +: 32] = 32'hA5A5_A5A5;
    b_rd(10'd3);
    chk("big_mask", b_rd_data, exp_big);
    b_wr(16'hFFFF, 10'd512, 32'h5555_AAAA);
    b_wr(16'hFFFF, 10'd1023, 32'hFFFF_0001);
    b_rd(10'd1023);
    chk("big_top_addr", b_rd_data, {16{32'hFFFF_0001}});
    b_clear_start = 1'b1;
    step();
    b_clear_start = 1'b0;
    nb = 0;
    while (b_busy && nb < 2000) begin
      nb++;
      step();
    end
    chk("big_clr_cycles", 32'(nb), 32'd1024);
    chk("big_clr_done", b_clear_done, 1'b1);
    b_rd(10'd0);
    chk("big_clr_addr0", b_rd_data, 512'h0);
    b_rd(10'd512);
    chk("big_clr_addr512", b_rd_data, 512'h0);
    b_rd(10'd1023);
    chk("big_clr_addr1023", b_rd_data, 512'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_ram_ctrl.md
Name: banked_ram_ctrl

Overview:
Parametrised bank of NUM_BANKS simple-dual-port RAMs. All banks share one write address and one read address. Features:
- Per-bank write masking, so one write can broadcast to any subset of banks.
- Concurrent read of all banks into one wide word.
- A built-in clear sequencer that zero-fills every bank.

It sits between the layer-sequencing logic and the compute datapath, holding per-layer activations and weights that are read out in parallel.

Parameters:
NUM_BANKS, 8, number of independent RAM banks (>=1)
BANK_DEPTH, 256, words per bank (>=2, power of two)
DATA_WIDTH, 16, bits per word per bank
AW (localparam), $clog2(BANK_DEPTH), address width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_bank_mask  in  NUM_BANKS  bank i written when wr_en && wr_bank_mask[i]
wr_addr  in  AW  write address, common to all banks
wr_data  in  DATA_WIDTH  write data, broadcast to all selected banks
wr_ready  out  1  =~busy; writes are only accepted when high
rd_en  in  1  read request, all banks
rd_addr  in  AW  read address, common to all banks
rd_data  out  NUM_BANKS*DATA_WIDTH  bank i at [i*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  1  rd_data holds the result of an accepted read
clear_start  in  1  request zero-fill of all banks
busy  out  1  clear sequence in progress
clear_done  out  1  one-cycle pulse on completion of a clear

Behaviour:
- Reset values:
  - FSM=IDLE, clear counter=0.
  - busy=0, clear_done=0, rd_valid=0, rd_data=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: accepts reads and writes. clear_start=1 moves to CLEAR in the next cycle, with the counter loaded to 0.
  - CLEAR: each cycle writes 0 to address counter in every bank, then increments the counter. When counter==BANK_DEPTH-1 that write completes the clear and the FSM moves to IDLE. clear_done=1 in that first IDLE cycle only.
  - Total CLEAR occupancy is exactly BANK_DEPTH cycles. busy=1 for exactly those cycles.
- Write path:
  - A write is accepted on an edge where wr_en && ~busy. It is committed at that edge.
  - wr_bank_mask==0 with wr_en=1 is a legal no-op.
  - During CLEAR, wr_en is ignored and dropped, not queued.
- Read path:
  - A read is accepted on an edge where rd_en && ~busy. Latency is 1 cycle: rd_data and rd_valid=1 in the following cycle.
  - rd_valid is 0 in any cycle that does not follow an accepted read.
  - rd_data holds its last value when no read is accepted. It is not zeroed.
  - During CLEAR, rd_en is ignored and rd_valid stays 0.
- Read/write collision:
  - Same address, same cycle: read-first. rd_data returns the pre-write contents for written banks and unchanged contents for unmasked banks.
  - A read at address A in the cycle after a write to A returns the new data.
- clear_start in the same IDLE cycle as rd_en/wr_en:
  - The read and write are serviced at that edge and the clear begins on the next edge.
  - The read result therefore reflects pre-clear contents, with rd_valid=1 in the first CLEAR cycle.
- clear_start while busy: ignored; no restart and no extension.
- Address wrap: the counter is exactly AW bits wide and never exceeds BANK_DEPTH-1. User addresses are always in range by width.
- rst asserted mid-CLEAR: the FSM returns to IDLE immediately, busy=0 and clear_done is not pulsed. Partially cleared contents are left as-is.
- No combinational path from any input to any output except wr_ready (=~busy, registered state).

Test Plan:
1. Basic read: write 16'hA5A5 to addr 3 with mask 8'b0000_0101, then read addr 3 -> one cycle later rd_valid=1. Banks 0 and 2 =A5A5; other banks hold their prior value.
2. Collision: with addr 7 holding 16'h0001 in all banks, write 16'h00FF (mask 8'hFF) and read addr 7 in the same cycle -> rd_data all 16'h0001. Re-read next cycle -> all 16'h00FF.
3. Clear sequence: fill all addresses with a nonzero pattern, pulse clear_start -> busy=1 for exactly 256 cycles and clear_done pulses once. Reads of addrs 0, 128 and 255 return all-zero.
4. Traffic during clear: assert wr_en (addr 10, 16'h1234) and rd_en throughout CLEAR -> rd_valid stays 0 and wr_ready=0. After completion addr 10 reads 0.
5. Mid-clear reset: pulse clear_start, assert rst at cycle 50 of CLEAR -> next cycle busy=0, clear_done=0, rd_valid=0. Addr 200 retains its pre-clear pattern.
6. Parameter sweep: NUM_BANKS=1/DEPTH=2/WIDTH=8 and NUM_BANKS=16/DEPTH=1024/WIDTH=32 -> repeat scenarios 1 and 3. Clear takes DEPTH cycles and lane mapping is correct.
